line_reader: RTL and testbench

//  Read-side partner of line_writer: streams one finished 240-row texture column out of the

---
 rtl/line_reader.sv | 156 +++++++++++++++
 tb/tb_line_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_reader.sv
// line_reader: streams one 240-row texture column out of the line_writer column RAM,
// row 0 first, as a valid/ready pixel stream tagged with row and screen column.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start while writer_rdy is high
// ST_READ  | issuing RAM addresses 1..LINES-1 as buffer credit allows
// ST_DRAIN | every address issued; emptying the skid buffer to the packer
//
// Read pipeline: an address written to ram_raddr at edge E is latched by the RAM
// at E+1, and its data is captured into the skid buffer at E+2 or later.
// p1 marks a read whose address is still waiting for the RAM to latch it.
// p2 marks a read whose data is on ram_read_data but has not been captured yet.
// Because ram_raddr holds when nothing new is issued, an uncaptured p2 read stays
// valid on the RAM bus. It only has to be captured on the edge after a newer
// address is issued. Issue is therefore allowed whenever that capture is certain
// to find a free skid slot. This sustains one pixel per cycle with a 2-entry buffer.
module line_reader #(
  parameter int LINES = 240,
  parameter int DW    = 8,
  parameter int CW    = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CW-1:0]            col,
  input  logic                     writer_rdy,
  output logic                     busy,
  output logic [$clog2(LINES)-1:0] ram_raddr,
  input  logic [DW-1:0]            ram_read_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_pixel,
  output logic [$clog2(LINES)-1:0] out_row,
  output logic [CW-1:0]            out_col,
  output logic                     out_last,
  output logic                     done
);
  localparam int AW = $clog2(LINES);
  localparam logic [AW-1:0] LAST_ROW = AW'(LINES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [DW-1:0] sk0_q, sk0_d;
  logic [DW-1:0] sk1_q, sk1_d;
  logic [1:0]    occ_q, occ_d;
  logic          p1_q, p1_d;
  logic          p2_q, p2_d;
  logic          done_q, done_d;

  logic          pop;
  logic          cap;
  logic          issue;
  logic [1:0]    occ_pop;

  // Skid buffer bookkeeping, read issue and the readout FSM.
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    row_d   = row_q;
    col_d   = col_q;
    sk0_d   = sk0_q;
    sk1_d   = sk1_q;
    p1_d    = 1'b0;
    done_d  = 1'b0;
    issue   = 1'b0;

    pop     = (occ_q != 2'd0) & out_ready;
    occ_pop = occ_q - {1'b0, pop};
    cap     = p2_q & (occ_pop != 2'd2);
    occ_d   = occ_pop + {1'b0, cap};

    if (pop) sk0_d = sk1_q;
    if (cap) begin
      if (occ_pop == 2'd0) sk0_d = ram_read_data;
      else                 sk1_d = ram_read_data;
    end

    // A read whose address was just latched by the RAM becomes capturable.
    // A capturable read that was not taken stays capturable.
    p2_d = p1_q | (p2_q & ~cap);

    // The head row advances with each accepted pixel.
    // It holds at the last row so that out_row stays in range until the next start.
    if (pop && (row_q != LAST_ROW)) row_d = row_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start && writer_rdy) begin
          state_d = ST_READ;
          raddr_d = '0;
          p1_d    = 1'b1;
          col_d   = col;
          row_d   = '0;
        end
      end
      ST_READ: begin
        // An older read left pending by this issue must find a slot next edge.
        issue = ~p2_d | (occ_d != 2'd2);
        if (issue) begin
          raddr_d = raddr_q + 1'b1;
          p1_d    = 1'b1;
          if ((raddr_q + 1'b1) == LAST_ROW) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && (row_q == LAST_ROW)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any readout in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      raddr_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      sk0_q   <= '0;
      sk1_q   <= '0;
      occ_q   <= 2'd0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sk0_q   <= sk0_d;
      sk1_q   <= sk1_d;
      occ_q   <= occ_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign ram_raddr = raddr_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_pixel = sk0_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = (occ_q != 2'd0) & (row_q == LAST_ROW);
  assign done      = done_q;

endmodule

// File: tb/tb_line_reader.sv
// Testbench for line_reader: a RAM model plus a queue-based reference of the expected
// pixel stream, filled from RAM contents whenever a start should be accepted.
module tb_line_reader;
  localparam int LINES = 240;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] col_in;
  logic       writer_rdy;
  logic       busy;
  logic [7:0] ram_raddr;
  logic [7:0] ram_read_data = 8'h00;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pixel;
  logic [7:0] out_row;
  logic [8:0] out_col;
  logic       out_last;
  logic       done;

  line_reader #(.LINES(LINES), .DW(8), .CW(9)) dut (
    .clk(clk), .rst(rst), .start(start), .col(col_in), .writer_rdy(writer_rdy),
    .busy(busy), .ram_raddr(ram_raddr), .ram_read_data(ram_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:LINES-1];
  always @(posedge clk) ram_read_data <= mem[ram_raddr];

  typedef struct {
    logic [7:0] pixel;
    logic [7:0] row;
    logic [8:0] col;
    logic       last;
  } exp_t;

  typedef struct {
    logic [8:0] col;
    logic       rdy;
    int         pct;
    int         mid_at;
    int         exp_beats;
    logic       exp_busy;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   beats = 0;
  int   ready_pct = 100;
  logic done_exp = 1'b0;
  logic stall_prev = 1'b0;
  logic [7:0] h_pix;
  logic [7:0] h_row;
  logic       h_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    out_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic try_start(input logic [8:0] c, input logic wrdy);
    start = 1'b1;
    col_in = c;
    writer_rdy = wrdy;
    if (wrdy && exp_q.size() == 0) begin
      for (int r = 0; r < LINES; r++) begin
        exp_t e;
        e.pixel = mem[r];
        e.row   = 8'(r);
        e.col   = c;
        e.last  = (r == LINES - 1);
        exp_q.push_back(e);
      end
    end
    cycle();
    start = 1'b0;
    writer_rdy = 1'b0;
  endtask

  task automatic wait_idle(input int mid_at, input logic [8:0] mid_col);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !busy) return;
      if (i == mid_at) try_start(mid_col, 1'b1);
      else cycle();
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_raddr"}, ram_raddr, 0);
    chk({pfx, "_valid"}, out_valid, 0);
    chk({pfx, "_pixel"}, out_pixel, 0);
    chk({pfx, "_row"}, out_row, 0);
    chk({pfx, "_col"}, out_col, 0);
    chk({pfx, "_last"}, out_last, 0);
    chk({pfx, "_done"}, done, 0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < LINES; r++) mem[r] = 8'($urandom);
  endtask

  // Stream monitor: in-order pixel reference, stall stability, address lead and done timing.
  always @(negedge clk) begin
    if (rst) begin
      chk("done_timing", done, done_exp);
      done_exp = 1'b0;
      if (stall_prev)
        chk("stall_hold", {out_valid, out_pixel, out_row, out_last}, {1'b1, h_pix, h_row, h_last});
      if (busy && exp_q.size() != 0)
        chk("raddr_lead", (int'(ram_raddr) <= (LINES - exp_q.size()) + 2), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("beat_expected", 0, 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat_pixel", out_pixel, e.pixel);
          chk("beat_row", out_row, e.row);
          chk("beat_col", out_col, e.col);
          chk("beat_last", out_last, e.last);
          if (e.last) done_exp = 1'b1;
        end
        beats++;
      end
      stall_prev = out_valid && !out_ready;
      h_pix  = out_pixel;
      h_row  = out_row;
      h_last = out_last;
    end
  end

  vec_t vecs[5];
  int   b0;
  int   n;

  initial begin
    vecs[0] = '{9'd100, 1'b1, 50, -1, 240, 1'b1};
    vecs[1] = '{9'd511, 1'b1, 50, 60, 240, 1'b1};
    vecs[2] = '{9'd0,   1'b1, 20, 100, 240, 1'b1};
    vecs[3] = '{9'd200, 1'b0, 100, -1, 0, 1'b0};
    vecs[4] = '{9'd3,   1'b1, 100, 10, 240, 1'b1};

    rst = 1'b0;
    start = 1'b0;
    col_in = '0;
    writer_rdy = 1'b0;
    out_ready = 1'b1;
    for (int r = 0; r < LINES; r++) mem[r] = 8'(r) ^ 8'h5A;

    repeat (4) @(posedge clk);
    #1;
    check_zero("rst_hold");
    rst = 1'b1;
    repeat (3) cycle();
    check_zero("post_rst");

    // Full-rate readout with latency checks on the first pixel.
    ready_pct = 100;
    b0 = beats;
    try_start(9'd100, 1'b1);
    chk("lat_busy", busy, 1);
    chk("lat_raddr", ram_raddr, 0);
    chk("lat_valid_n", out_valid, 0);
    cycle();
    chk("lat_valid_n1", out_valid, 0);
    cycle();
    chk("lat_valid_n2", out_valid, 1);
    chk("lat_pix0", out_pixel, 8'h5A);
    chk("lat_col", out_col, 100);
    wait_idle(-1, 9'd0);
    chk("stream_beats", beats - b0, 240);

    // Table of readouts: backpressure levels, ignored starts, mid-readout start pulses.
    for (int i = 0; i < 5; i++) begin
      fill_random();
      ready_pct = vecs[i].pct;
      b0 = beats;
      try_start(vecs[i].col, vecs[i].rdy);
      chk("vec_busy", busy, vecs[i].exp_busy);
      wait_idle(vecs[i].mid_at, vecs[i].col ^ 9'h155);
      chk("vec_beats", beats - b0, vecs[i].exp_beats);
    end

    // Reset while row 117 is the next pixel to be accepted.
    fill_random();
    ready_pct = 70;
    try_start(9'd55, 1'b1);
    n = 0;
    while ((LINES - exp_q.size()) < 117 && n < 2000) begin
      cycle();
      n++;
    end
    chk("rst_mid_reach", LINES - exp_q.size(), 117);
    rst = 1'b0;
    exp_q.delete();
    done_exp = 1'b0;
    stall_prev = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (2) cycle();
    rst = 1'b1;
    repeat (2) cycle();
    b0 = beats;
    try_start(9'd77, 1'b1);
    wait_idle(-1, 9'd0);
    chk("rst_mid_restart_beats", beats - b0, 240);

    // Back-to-back: second start issued in the cycle done pulses.
    fill_random();
    ready_pct = 100;
    b0 = beats;
    try_start(9'd300, 1'b1);
    n = 0;
    while (!done && n < 1000) begin
      cycle();
      n++;
    end
    chk("b2b_done_seen", done, 1);
    try_start(9'd301, 1'b1);
    chk("b2b_busy", busy, 1);
    wait_idle(-1, 9'd0);
    chk("b2b_beats", beats - b0, 480);

    repeat (3) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
